// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_parser_pkg;

  // Parser states; the values are fixed so they read the same in every tool.
  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    OUT     = 3'd4
  } state_t;

  // Error codes reported on err_code; ERR_NONE is only seen before the first error.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN bytes, one synchronous write port, one combinational read port.
module uart_frame_buf #(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_idx,
  output logic [7:0] rd_data
);

  localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] DEPTH = 8'(MAX_LEN);

  logic [7:0] mem [MAX_LEN];

  // Store one payload byte per write; reset wipes any partially received frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_idx < DEPTH)) begin
      mem[wr_idx[AW-1:0]] <= wr_data;
    end
  end

  // Out-of-range reads return zero rather than aliasing onto a real entry.
  always_comb begin
    rd_data = '0;
    if (rd_idx < DEPTH) begin
      rd_data = mem[rd_idx[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: header, length, payload, checksum; replays only verified payloads.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int         CLK_FRE    = 50,
  parameter int         TIMEOUT_US = 1000,
  parameter logic [7:0] HEADER     = DEFAULT_HEADER,
  parameter int         MAX_LEN    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [7:0]  frame_len,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] err_cnt
);

  localparam int          TIMEOUT_CYCLES = CLK_FRE * TIMEOUT_US;
  localparam logic [31:0] TIMEOUT_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  MAX_LEN_B      = 8'(MAX_LEN);

  state_t     state;
  state_t     next_state;
  logic       ready_q;
  logic [7:0] len_q;
  logic [7:0] sum_q;
  logic [7:0] idx_q;
  logic [7:0] rd_idx_q;
  logic [31:0] timer_q;
  logic       err_event;
  err_code_t  err_kind;
  logic       accept;
  logic       last_beat;
  logic       in_frame;
  logic       timer_expired;
  logic       buf_wr_en;
  logic [7:0] rd_data;

  assign accept        = rx_data_valid && rx_data_ready;
  assign last_beat     = (rd_idx_q == (len_q - 8'd1));
  assign in_frame      = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  assign timer_expired = (timer_q == TIMEOUT_LAST);
  assign buf_wr_en     = (state == PAYLOAD) && accept;

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr_en),
    .wr_idx  (idx_q),
    .wr_data (rx_data),
    .rd_idx  (rd_idx_q),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and error decode; an accepted byte always wins over a timer expiry.
  always_comb begin
    next_state = state;
    err_event  = 1'b0;
    err_kind   = ERR_NONE;
    case (state)
      HUNT: begin
        if (accept && (rx_data == HEADER)) begin
          next_state = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            next_state = HUNT;
            err_event  = 1'b1;
            err_kind   = ERR_LEN;
          end else begin
            next_state = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept && (idx_q == (len_q - 8'd1))) begin
          next_state = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          if (rx_data == sum_q) begin
            next_state = OUT;
          end else begin
            next_state = HUNT;
            err_event  = 1'b1;
            err_kind   = ERR_CSUM;
          end
        end
      end
      OUT: begin
        if (out_ready && last_beat) begin
          next_state = HUNT;
        end
      end
      default: begin
        next_state = HUNT;
      end
    endcase
    if (in_frame && !accept && timer_expired) begin
      next_state = HUNT;
      err_event  = 1'b1;
      err_kind   = ERR_TIMEOUT;
    end
  end

  // Output decode; the replay stream is driven straight from the state register and buffer.
  always_comb begin
    out_valid     = (state == OUT);
    out_last      = (state == OUT) && last_beat;
    out_data      = (state == OUT) ? rd_data : 8'h00;
    rx_data_ready = ready_q;
  end

  // Upstream ready is registered and drops only while the frame is being replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (next_state != OUT);
    end
  end

  // Length, running checksum, write index and replay index bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      rd_idx_q  <= '0;
      frame_len <= '0;
    end else begin
      case (state)
        LEN: begin
          if (accept && (next_state == PAYLOAD)) begin
            len_q <= rx_data;
            sum_q <= rx_data;
            idx_q <= '0;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            sum_q <= sum_q + rx_data;
            idx_q <= idx_q + 8'd1;
          end
        end
        CSUM: begin
          if (accept && (next_state == OUT)) begin
            rd_idx_q  <= '0;
            frame_len <= len_q;
          end
        end
        OUT: begin
          if (out_ready) begin
            rd_idx_q <= rd_idx_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Inter-byte gap timer; only counts while waiting for the next byte of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (in_frame && !accept && !timer_expired) begin
      timer_q <= timer_q + 32'd1;
    end else begin
      timer_q <= '0;
    end
  end

  // Error pulse, sticky error code and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      err_cnt   <= 16'd0;
    end else begin
      frame_err <= err_event;
      if (err_event) begin
        err_code <= err_kind;
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed vector table, corner sequences, random frames.
module tb_uart_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_valid = 1'b0;
  logic        rx_data_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic [7:0]  frame_len;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] err_cnt;

  uart_frame_parser dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .frame_len     (frame_len),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .err_cnt       (err_cnt)
  );

  typedef struct {
    string        name;
    int           n_in;
    logic [191:0] in_bytes;
    int           n_out;
    logic [127:0] out_bytes;
    int           n_err;
    logic [1:0]   code;
  } vec_t;

  vec_t       vecs[6];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         ready_mode = 0;
  int         last_acc_cyc = 0;
  int         long_err = 0;
  logic       prev_err = 1'b0;
  int         err_total = 0;
  logic [8:0] got_b[$];
  int         got_cyc[$];
  logic [7:0] got_l[$];
  logic [1:0] got_c[$];
  logic [7:0] stream_q[$];
  logic [8:0] exp_b[$];
  logic [7:0] exp_l[$];
  logic [1:0] exp_c[$];

  // 100 MHz-style clock; the design only cares about cycles.
  always #5 clk = ~clk;

  // Cycle counter used for latency and gap measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records output beats, frame lengths and error pulses mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_b.push_back({out_last, out_data});
        got_cyc.push_back(cyc);
        if (out_last) got_l.push_back(frame_len);
      end
      if (frame_err) got_c.push_back(err_code);
      if (frame_err && prev_err) long_err++;
    end
    prev_err = frame_err;
  end

  // Downstream ready driver: 0 = stalled, 1 = always ready, other = random.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Hang guard.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Offer one byte and hold it until accepted; called just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_data = b;
    rx_data_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_data_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!rx_data_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_wait: byte %02h not accepted, rx_data_ready %0b expected 1", b, rx_data_ready);
    end else begin
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_stream(input int max_gap);
    for (int i = 0; i < stream_q.size(); i++) begin
      send_byte(stream_q[i], $urandom_range(0, max_gap));
    end
  endtask

  task automatic apply_stimulus(input int v);
    stream_q.delete();
    for (int i = 0; i < vecs[v].n_in; i++) begin
      stream_q.push_back(vecs[v].in_bytes[(vecs[v].n_in - 1 - i) * 8 +: 8]);
    end
    send_stream(0);
  endtask

  // Reference parser working on the whole byte stream at once.
  task automatic run_model();
    int p;
    int len;
    int sum;
    exp_b.delete();
    exp_l.delete();
    exp_c.delete();
    p = 0;
    while (p < stream_q.size()) begin
      if (stream_q[p] != 8'hA5) begin
        p++;
        continue;
      end
      p++;
      if (p >= stream_q.size()) break;
      len = int'(stream_q[p]);
      p++;
      if (len == 0 || len > 16) begin
        exp_c.push_back(2'd1);
        continue;
      end
      if (p + len >= stream_q.size()) break;
      sum = len;
      for (int k = 0; k < len; k++) sum += int'(stream_q[p + k]);
      if (int'(stream_q[p + len]) == (sum % 256)) begin
        for (int k = 0; k < len; k++) exp_b.push_back({(k == len - 1), stream_q[p + k]});
        exp_l.push_back(8'(len));
      end else begin
        exp_c.push_back(2'd2);
      end
      p += len + 1;
    end
  endtask

  task automatic push_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d, input int n);
    stream_q.delete();
    stream_q.push_back(a);
    if (n > 1) stream_q.push_back(b);
    if (n > 2) stream_q.push_back(c);
    if (n > 3) stream_q.push_back(d);
  endtask

  initial begin
    int hb, hc, hl, nb, nc, bad, t0, n, dt;
    logic [7:0] bv;
    int len, sum, kind;

    vecs[0].name = "good3";     vecs[0].n_in = 6;
    vecs[0].in_bytes = 192'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    vecs[0].n_out = 3; vecs[0].out_bytes = 128'({8'h11, 8'h22, 8'h33}); vecs[0].n_err = 0; vecs[0].code = 2'd0;
    vecs[1].name = "badcsum";   vecs[1].n_in = 6;
    vecs[1].in_bytes = 192'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00});
    vecs[1].n_out = 0; vecs[1].out_bytes = 128'h0; vecs[1].n_err = 1; vecs[1].code = 2'd2;
    vecs[2].name = "good1";     vecs[2].n_in = 4;
    vecs[2].in_bytes = 192'({8'hA5, 8'h01, 8'h7E, 8'h7F});
    vecs[2].n_out = 1; vecs[2].out_bytes = 128'h7E; vecs[2].n_err = 0; vecs[2].code = 2'd0;
    vecs[3].name = "badlen";    vecs[3].n_in = 4;
    vecs[3].in_bytes = 192'({8'hA5, 8'h00, 8'hA5, 8'h11});
    vecs[3].n_out = 0; vecs[3].out_bytes = 128'h0; vecs[3].n_err = 2; vecs[3].code = 2'd1;
    vecs[4].name = "noise_hdr"; vecs[4].n_in = 8;
    vecs[4].in_bytes = 192'({8'h00, 8'hFF, 8'h55, 8'hA5, 8'h02, 8'hA5, 8'h10, 8'hB7});
    vecs[4].n_out = 2; vecs[4].out_bytes = 128'({8'hA5, 8'h10}); vecs[4].n_err = 0; vecs[4].code = 2'd0;
    vecs[5].name = "maxlen";    vecs[5].n_in = 19;
    vecs[5].in_bytes = 192'({8'hA5, 8'h10, 128'h000102030405060708090A0B0C0D0E0F, 8'h88});
    vecs[5].n_out = 16; vecs[5].out_bytes = 128'h000102030405060708090A0B0C0D0E0F; vecs[5].n_err = 0; vecs[5].code = 2'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_rx_ready", rx_data_ready, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_last", out_last, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_frame_len", frame_len, 0);
    check_output("rst_frame_err", frame_err, 0);
    check_output("rst_err_code", err_code, 0);
    check_output("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    check_output("post_rst_rx_ready", rx_data_ready, 1);

    // Directed vector table, downstream always ready
    for (int v = 0; v < 6; v++) begin
      hb = got_b.size(); hc = got_c.size(); hl = got_l.size();
      apply_stimulus(v);
      repeat (30) begin @(posedge clk); #1; end
      err_total += vecs[v].n_err;
      nb = got_b.size() - hb;
      nc = got_c.size() - hc;
      check_output($sformatf("%s_out_count", vecs[v].name), nb, vecs[v].n_out);
      for (int i = 0; i < vecs[v].n_out && i < nb; i++) begin
        check_output($sformatf("%s_beat%0d", vecs[v].name, i), got_b[hb + i],
                     {(i == vecs[v].n_out - 1), vecs[v].out_bytes[(vecs[v].n_out - 1 - i) * 8 +: 8]});
      end
      if (vecs[v].n_out > 0 && nb == vecs[v].n_out) begin
        check_output($sformatf("%s_latency", vecs[v].name), got_cyc[hb], last_acc_cyc + 1);
        check_output($sformatf("%s_gapless", vecs[v].name), got_cyc[hb + nb - 1] - got_cyc[hb], nb - 1);
        check_output($sformatf("%s_frame_len", vecs[v].name), (got_l.size() > hl) ? got_l[hl] : 8'h00, vecs[v].n_out);
      end
      check_output($sformatf("%s_err_pulses", vecs[v].name), nc, vecs[v].n_err);
      if (vecs[v].n_err > 0) begin
        check_output($sformatf("%s_err_code", vecs[v].name), err_code, vecs[v].code);
      end
      check_output($sformatf("%s_err_cnt", vecs[v].name), err_cnt, err_total);
      check_output($sformatf("%s_idle_valid", vecs[v].name), out_valid, 0);
      check_output($sformatf("%s_idle_ready", vecs[v].name), rx_data_ready, 1);
    end

    // Backpressure: replay stalls, upstream byte is held off, no timeout
    hb = got_b.size(); hc = got_c.size();
    ready_mode = 0;
    push_bytes(8'h00, 8'hFF, 8'h55, 8'hA5, 4);
    send_stream(0);
    push_bytes(8'h02, 8'hA5, 8'h10, 8'hB7, 4);
    send_stream(0);
    rx_data = 8'h33;
    rx_data_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b0 || rx_data_ready !== 1'b0 || frame_err !== 1'b0) bad++;
    end
    check_output("bp_hold_bad_cycles", bad, 0);
    check_output("bp_hold_data", out_data, 8'hA5);
    check_output("bp_hold_rx_ready", rx_data_ready, 0);
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
    ready_mode = 1;
    repeat (10) begin @(posedge clk); #1; end
    check_output("bp_out_count", got_b.size() - hb, 2);
    if (got_b.size() - hb >= 2) begin
      check_output("bp_beat0", got_b[hb], {1'b0, 8'hA5});
      check_output("bp_beat1", got_b[hb + 1], {1'b1, 8'h10});
    end
    check_output("bp_no_err", got_c.size() - hc, 0);

    // Timeout inside a frame, then recovery
    hb = got_b.size(); hc = got_c.size();
    push_bytes(8'hA5, 8'h02, 8'h11, 8'h00, 3);
    send_stream(0);
    t0 = last_acc_cyc;
    n = 0;
    @(negedge clk);
    while (!frame_err && n < 60000) begin
      n++;
      @(negedge clk);
    end
    dt = cyc - t0;
    check_output("to_seen", frame_err, 1);
    check_output("to_window", (dt >= 49995 && dt <= 50005), 1);
    check_output("to_err_code", err_code, 2'd3);
    err_total++;
    check_output("to_err_cnt", err_cnt, err_total);
    @(posedge clk);
    #1;
    push_bytes(8'hA5, 8'h01, 8'h42, 8'h43, 4);
    send_stream(0);
    repeat (10) begin @(posedge clk); #1; end
    check_output("to_recover_count", got_b.size() - hb, 1);
    if (got_b.size() > hb) check_output("to_recover_beat", got_b[hb], {1'b1, 8'h42});
    check_output("to_err_pulses", got_c.size() - hc, 1);

    // Randomized frames against the reference parser
    hb = got_b.size(); hc = got_c.size(); hl = got_l.size();
    stream_q.delete();
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        len = $urandom_range(1, 16);
        stream_q.push_back(8'hA5);
        stream_q.push_back(8'(len));
        sum = len;
        for (int k = 0; k < len; k++) begin
          bv = 8'($urandom_range(0, 255));
          stream_q.push_back(bv);
          sum += int'(bv);
        end
        if (kind <= 4) stream_q.push_back(8'(sum));
        else stream_q.push_back(8'(sum + $urandom_range(1, 255)));
      end else if (kind == 7) begin
        stream_q.push_back(8'hA5);
        stream_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
      end else begin
        repeat ($urandom_range(1, 3)) begin
          bv = 8'($urandom_range(0, 255));
          stream_q.push_back((bv == 8'hA5) ? 8'h00 : bv);
        end
      end
    end
    run_model();
    ready_mode = 2;
    send_stream(2);
    n = 0;
    while (((got_b.size() - hb) < exp_b.size() || (got_c.size() - hc) < exp_c.size()) && n < 3000) begin
      n++;
      @(posedge clk);
      #1;
    end
    ready_mode = 1;
    repeat (5) begin @(posedge clk); #1; end
    err_total += exp_c.size();
    check_output("rnd_out_count", got_b.size() - hb, exp_b.size());
    for (int i = 0; i < exp_b.size() && (hb + i) < got_b.size(); i++) begin
      check_output($sformatf("rnd_beat%0d", i), got_b[hb + i], exp_b[i]);
    end
    check_output("rnd_frame_count", got_l.size() - hl, exp_l.size());
    for (int i = 0; i < exp_l.size() && (hl + i) < got_l.size(); i++) begin
      check_output($sformatf("rnd_frame_len%0d", i), got_l[hl + i], exp_l[i]);
    end
    check_output("rnd_err_count", got_c.size() - hc, exp_c.size());
    for (int i = 0; i < exp_c.size() && (hc + i) < got_c.size(); i++) begin
      check_output($sformatf("rnd_err_code%0d", i), got_c[hc + i], exp_c[i]);
    end
    check_output("rnd_err_cnt", err_cnt, err_total);

    // Reset in the middle of a payload discards the partial frame
    push_bytes(8'hA5, 8'h03, 8'h11, 8'h00, 3);
    send_stream(0);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midrst_rx_ready", rx_data_ready, 0);
    check_output("midrst_err_cnt", err_cnt, 0);
    check_output("midrst_frame_len", frame_len, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    err_total = 0;
    hb = got_b.size(); hc = got_c.size();
    push_bytes(8'h22, 8'h33, 8'h69, 8'h00, 3);
    send_stream(0);
    push_bytes(8'hA5, 8'h01, 8'h7E, 8'h7F, 4);
    send_stream(0);
    repeat (10) begin @(posedge clk); #1; end
    check_output("midrst_out_count", got_b.size() - hb, 1);
    if (got_b.size() > hb) check_output("midrst_beat", got_b[hb], {1'b1, 8'h7E});
    check_output("midrst_no_err", got_c.size() - hc, 0);

    // Error counter saturation
    force dut.err_cnt = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.err_cnt;
    @(negedge clk);
    check_output("sat_preload", err_cnt, 16'hFFFE);
    @(posedge clk);
    #1;
    push_bytes(8'hA5, 8'h00, 8'h00, 8'h00, 2);
    send_stream(0);
    repeat (3) begin @(posedge clk); #1; end
    check_output("sat_reach", err_cnt, 16'hFFFF);
    check_output("sat_code_len", err_code, 2'd1);
    push_bytes(8'hA5, 8'h01, 8'h11, 8'h00, 4);
    send_stream(0);
    repeat (3) begin @(posedge clk); #1; end
    check_output("sat_hold", err_cnt, 16'hFFFF);
    check_output("sat_code_csum", err_code, 2'd2);

    check_output("err_pulse_width", long_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
